// File: rtl/test_sys_top_qsys_pio_defs.sv
// Shared definitions for the Qsys output PIO: register word addresses and the
// pulse timer state encoding.
package test_sys_top_qsys_pio_defs;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_OUTSET = 2'd2;
  localparam logic [1:0] ADDR_OUTCLR = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PULSING = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/test_sys_top_qsys_pio_pulse_timer.sv
// One-shot timer for the output PIO: counts non-write cycles down from
// PULSE_CYCLES-1 and flags a single-cycle expire when the pulse ends.
module test_sys_top_qsys_pio_pulse_timer
  import test_sys_top_qsys_pio_defs::*;
#(
  parameter int PULSE_CYCLES = 5000000,
  parameter int CNT_W        = 23
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic hold,
  input  logic kill,
  output logic expire,
  output logic busy
);

  pulse_state_e     state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Any bus write freezes the countdown, so expiry slides to the next idle cycle.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    expire    = 1'b0;
    if (load) begin
      state_nxt = PULSING;
      count_nxt = CNT_W'(PULSE_CYCLES - 1);
    end else if (kill) begin
      state_nxt = IDLE;
    end else if (state == PULSING && !hold) begin
      if (count == '0) begin
        expire    = 1'b1;
        state_nxt = IDLE;
      end else begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  assign busy = (state == PULSING);

endmodule

// File: rtl/test_sys_top_qsys_led_pio_out.sv
// Avalon-MM output PIO with DATA/PULSE/OUTSET/OUTCLR registers; out_port comes
// straight from data_reg and pulsed bits are cleared by the one-shot timer.
module test_sys_top_qsys_led_pio_out
  import test_sys_top_qsys_pio_defs::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PULSE_CYCLES = 5000000,
  parameter int                    CNT_W        = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] data_reg, data_nxt;
  logic [DATA_WIDTH-1:0] pulse_mask, mask_nxt;
  logic [DATA_WIDTH-1:0] m;
  logic [31:0]           rd_nxt;
  logic                  wr, load, kill, expire, busy;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign m         = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_comb begin
    data_nxt = data_reg;
    mask_nxt = pulse_mask;
    if (wr) begin
      unique case (address)
        ADDR_DATA: begin
          data_nxt = m;
          mask_nxt = '0;
        end
        ADDR_PULSE: begin
          data_nxt = data_reg | m;
          mask_nxt = pulse_mask | m;
        end
        ADDR_OUTSET: begin
          data_nxt = data_reg | m;
          mask_nxt = pulse_mask & ~m;
        end
        default: begin
          data_nxt = data_reg & ~m;
          mask_nxt = pulse_mask & ~m;
        end
      endcase
    end else if (expire) begin
      data_nxt = data_reg & ~pulse_mask;
      mask_nxt = '0;
    end
  end

  assign load = wr && (address == ADDR_PULSE) && (m != '0);
  assign kill = wr && (mask_nxt == '0);

  test_sys_top_qsys_pio_pulse_timer #(
    .PULSE_CYCLES(PULSE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .hold   (wr),
    .kill   (kill),
    .expire (expire),
    .busy   (busy)
  );

  always_comb begin
    rd_nxt = '0;
    unique case (address)
      ADDR_DATA:   rd_nxt = 32'(data_reg);
      ADDR_PULSE:  rd_nxt = 32'(pulse_mask);
      ADDR_OUTSET: rd_nxt = 32'(busy);
      default:     rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= RESET_VALUE;
      pulse_mask <= '0;
      readdata   <= '0;
    end else begin
      data_reg   <= data_nxt;
      pulse_mask <= mask_nxt;
      readdata   <= rd_nxt;
    end
  end

  assign out_port = data_reg;

endmodule

// File: tb/tb_test_sys_top_qsys_led_pio_out.sv
// Bench for the output PIO: directed vector table, randomized traffic against a
// cycle-count reference model, and an asynchronous reset in the middle of a pulse.
module tb_test_sys_top_qsys_led_pio_out;

  localparam int         PC = 4;
  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  test_sys_top_qsys_led_pio_out #(
    .DATA_WIDTH  (8),
    .RESET_VALUE (RV),
    .PULSE_CYCLES(PC),
    .CNT_W       (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  // Reference model: pulse bits stay up for PC write-free clock edges.
  logic [7:0]  m_data, m_mask;
  bit          m_busy;
  int          m_left;
  logic [31:0] m_rd;

  task automatic model_reset();
    m_data = RV; m_mask = 8'h00; m_busy = 1'b0; m_left = 0; m_rd = 32'd0;
  endtask

  task automatic model_step(input logic [1:0] a, input bit wr, input logic [31:0] wd);
    logic [7:0] m;
    m = wd[7:0];
    case (a)
      2'd0:    m_rd = {24'd0, m_data};
      2'd1:    m_rd = {24'd0, m_mask};
      2'd2:    m_rd = {31'd0, m_busy};
      default: m_rd = 32'd0;
    endcase
    if (wr) begin
      case (a)
        2'd0: begin m_data = m; m_mask = 8'h00; end
        2'd1: if (m != 8'h00) begin
          m_data = m_data | m; m_mask = m_mask | m; m_left = PC; m_busy = 1'b1;
        end
        2'd2: begin m_data = m_data | m; m_mask = m_mask & ~m; end
        default: begin m_data = m_data & ~m; m_mask = m_mask & ~m; end
      endcase
      if (m_mask == 8'h00) m_busy = 1'b0;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_data = m_data & ~m_mask; m_mask = 8'h00; m_busy = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; applies one bus cycle and returns at the following negedge.
  task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    model_step(a, cs & ~wn, wd);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[30];

  initial begin
    // reads/writes, then pulse length, retrigger, sticky OUTSET and deferred expiry
    vecs[0]  = '{2'd0, 1'b0, 32'h0,        8'hA5, 32'hA5};
    vecs[1]  = '{2'd0, 1'b1, 32'hFFFF_FF3C, 8'h3C, 32'hA5};
    vecs[2]  = '{2'd0, 1'b0, 32'h0,        8'h3C, 32'h3C};
    vecs[3]  = '{2'd2, 1'b1, 32'h0000_00C3, 8'hFF, 32'h0};
    vecs[4]  = '{2'd0, 1'b0, 32'h0,        8'hFF, 32'hFF};
    vecs[5]  = '{2'd3, 1'b1, 32'h0000_000F, 8'hF0, 32'h0};
    vecs[6]  = '{2'd0, 1'b0, 32'h0,        8'hF0, 32'hF0};
    vecs[7]  = '{2'd0, 1'b1, 32'h0,        8'h00, 32'hF0};
    vecs[8]  = '{2'd1, 1'b1, 32'h01,       8'h01, 32'h0};
    vecs[9]  = '{2'd2, 1'b0, 32'h0,        8'h01, 32'h1};
    vecs[10] = '{2'd1, 1'b0, 32'h0,        8'h01, 32'h01};
    vecs[11] = '{2'd0, 1'b0, 32'h0,        8'h01, 32'h01};
    vecs[12] = '{2'd2, 1'b0, 32'h0,        8'h00, 32'h1};
    vecs[13] = '{2'd2, 1'b0, 32'h0,        8'h00, 32'h0};
    vecs[14] = '{2'd1, 1'b1, 32'h01,       8'h01, 32'h0};
    vecs[15] = '{2'd1, 1'b0, 32'h0,        8'h01, 32'h01};
    vecs[16] = '{2'd1, 1'b1, 32'h02,       8'h03, 32'h01};
    vecs[17] = '{2'd1, 1'b0, 32'h0,        8'h03, 32'h03};
    vecs[18] = '{2'd1, 1'b0, 32'h0,        8'h03, 32'h03};
    vecs[19] = '{2'd1, 1'b0, 32'h0,        8'h03, 32'h03};
    vecs[20] = '{2'd1, 1'b0, 32'h0,        8'h00, 32'h03};
    vecs[21] = '{2'd1, 1'b0, 32'h0,        8'h00, 32'h00};
    vecs[22] = '{2'd1, 1'b1, 32'h03,       8'h03, 32'h0};
    vecs[23] = '{2'd2, 1'b1, 32'h01,       8'h03, 32'h1};
    vecs[24] = '{2'd1, 1'b0, 32'h0,        8'h03, 32'h02};
    vecs[25] = '{2'd1, 1'b0, 32'h0,        8'h03, 32'h02};
    vecs[26] = '{2'd1, 1'b0, 32'h0,        8'h03, 32'h02};
    vecs[27] = '{2'd2, 1'b1, 32'h00,       8'h03, 32'h1};
    vecs[28] = '{2'd0, 1'b0, 32'h0,        8'h01, 32'h03};
    vecs[29] = '{2'd2, 1'b0, 32'h0,        8'h01, 32'h0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_port", {24'd0, out_port}, {24'd0, RV});
    chk("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].addr, 1'b1, ~vecs[i].wr, vecs[i].wd);
      chk($sformatf("vec%0d_out", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end

    // randomized traffic against the model from a fresh reset
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic        cs, wn;
      logic [31:0] wd;
      a  = 2'($urandom_range(0, 3));
      cs = ($urandom_range(0, 9) != 0);
      wn = ($urandom_range(0, 9) > 2);
      wd = $urandom;
      if (a == 2'd1 && $urandom_range(0, 5) == 0) wd[7:0] = 8'h00;
      if (a == 2'd0 || a == 2'd3) wd[7:0] = wd[7:0] & 8'(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h0F);
      drive(a, cs, wn, wd);
      chk($sformatf("rnd%0d_out", i), {24'd0, out_port}, {24'd0, m_data});
      chk($sformatf("rnd%0d_rd", i), readdata, m_rd);
    end

    // asynchronous reset in the middle of a pulse
    drive(2'd0, 1'b1, 1'b0, 32'h0);
    drive(2'd1, 1'b1, 1'b0, 32'hFF);
    chk("mid_pulse_out", {24'd0, out_port}, 32'hFF);
    drive(2'd2, 1'b1, 1'b1, 32'h0);
    chk("mid_pulse_busy", readdata, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", {24'd0, out_port}, {24'd0, RV});
    chk("async_rst_rd", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 1'b1, 1'b1, 32'h0);
      chk($sformatf("post_rst%0d_out", i), {24'd0, out_port}, {24'd0, RV});
      chk($sformatf("post_rst%0d_busy", i), readdata, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
